// File: rtl/mpp_peek_dispatcher.sv
// Peeks a window from mpp_fifo and sends its valid entries one word at a time
// on a valid/ready stream, then pops exactly the words that were accepted.
module mpp_peek_dispatcher #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PEEK_WIDTH = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_nrst,
    input  logic                                   i_clear,
    input  logic                                   i_start,
    input  logic [COUNT_W-1:0]                     i_count,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_peek_en,
    input  logic [0:PEEK_WIDTH-1][DATA_WIDTH-1:0]  i_peek_data,
    input  logic [0:PEEK_WIDTH-1]                  i_valid_data,
    input  logic                                   i_peek_valid,
    input  logic                                   i_fifo_empty,
    output logic                                   o_pop_en,
    output logic [0:PEEK_WIDTH-1]                  o_data_hit,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic                                   o_valid,
    input  logic                                   i_ready
);

    localparam int unsigned IDX_W = (PEEK_WIDTH > 1) ? $clog2(PEEK_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPeek,
        StLatch,
        StSend,
        StPop,
        StDone
    } state_e;

    state_e                                state_q, state_d;
    logic [COUNT_W-1:0]                    rem_q, rem_d;
    logic [0:PEEK_WIDTH-1][DATA_WIDTH-1:0] win_q, win_d;
    logic [0:PEEK_WIDTH-1]                 vmask_q, vmask_d;
    logic [0:PEEK_WIDTH-1]                 hit_q, hit_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;

    logic             first_found;
    logic [IDX_W-1:0] first_idx;
    logic             next_found;
    logic [IDX_W-1:0] next_idx;

    // Lowest set bit of the incoming mask; scanning downwards leaves the lowest.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = int'(PEEK_WIDTH) - 1; i >= 0; i--) begin
            if (i_valid_data[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
        end
    end

    // Next captured valid entry strictly above the one being sent.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = int'(PEEK_WIDTH) - 1; i >= 0; i--) begin
            if (vmask_q[i] && (i > int'(idx_q))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rem_q   <= '0;
            win_q   <= '0;
            vmask_q <= '0;
            hit_q   <= '0;
            idx_q   <= '0;
        end else begin
            rem_q   <= rem_d;
            win_q   <= win_d;
            vmask_q <= vmask_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        win_d   = win_q;
        vmask_d = vmask_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        rem_d   = i_count;
                        state_d = StPeek;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPeek: begin
                if (!i_fifo_empty) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (i_peek_valid) begin
                    win_d   = i_peek_data;
                    vmask_d = i_valid_data;
                    hit_d   = '0;
                    idx_d   = first_idx;
                    state_d = first_found ? StSend : StPeek;
                end
            end
            StSend: begin
                if (i_ready) begin
                    hit_d[idx_q] = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    idx_d = next_idx;
                    if ((rem_q <= COUNT_W'(1)) || !next_found) begin
                        state_d = StPop;
                    end
                end
            end
            StPop: begin
                state_d = (rem_q == '0) ? StDone : StPeek;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort drops captured words without popping them.
        if (i_clear) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        o_busy     = (state_q != StIdle);
        o_done     = 1'b0;
        o_peek_en  = 1'b0;
        o_pop_en   = 1'b0;
        o_data_hit = '0;
        o_data     = '0;
        o_valid    = 1'b0;
        unique case (state_q)
            StPeek: o_peek_en = !i_fifo_empty;
            StSend: begin
                o_valid = 1'b1;
                o_data  = win_q[idx_q];
            end
            StPop: begin
                o_pop_en   = 1'b1;
                o_data_hit = hit_q;
            end
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mpp_peek_dispatcher.md
Name: mpp_peek_dispatcher

Overview:
- Downstream consumer of mpp_fifo (multi-push/peek-pop FIFO).
- Repeatedly peeks a PEEK_WIDTH window and serializes its valid entries onto a single valid/ready word stream toward the PE feed.
- Then returns an i_data_hit-style pop mask so the FIFO retires exactly the words consumed.
- Each job transfers a programmed word count, then pulses done.

Parameters:
- DATA_WIDTH, 8, bits per data word (matches mpp_fifo).
- PEEK_WIDTH, 4, peek window size (matches mpp_fifo).
- COUNT_W, 16, width of the job word counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_nrst  in  1  reset, asynchronous active-low.
- i_clear  in  1  synchronous abort to IDLE.
- i_start  in  1  start job; sampled in IDLE only.
- i_count  in  COUNT_W  words to transfer; sampled with i_start.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse at job end.
- o_peek_en  out  1  to mpp_fifo i_peek_en.
- i_peek_data  in  [0:PEEK_WIDTH-1][DATA_WIDTH-1:0]  from mpp_fifo o_peek_data; index 0 = oldest.
- i_valid_data  in  [0:PEEK_WIDTH-1]  from mpp_fifo o_valid_data.
- i_peek_valid  in  1  from mpp_fifo o_peek_valid.
- i_fifo_empty  in  1  from mpp_fifo o_empty.
- o_pop_en  out  1  to mpp_fifo i_pop_en.
- o_data_hit  out  [0:PEEK_WIDTH-1]  to mpp_fifo i_data_hit; bit index i retires peek index i.
- o_data  out  DATA_WIDTH  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready.

Behaviour:
- Reset (i_nrst=0, async): state=IDLE; all outputs 0; window, mask and counter registers cleared.
- States: IDLE, PEEK, LATCH, SEND, POP, DONE.
- IDLE
  - i_start=1 and i_count>0: rem<=i_count, go to PEEK.
  - i_start=1 and i_count=0: go to DONE.
  - i_start ignored in every other state.
- PEEK
  - i_fifo_empty=1: hold in PEEK, o_peek_en=0.
  - Otherwise: o_peek_en=1 for exactly one cycle, then go to LATCH.
- LATCH
  - Hold until i_peek_valid=1.
  - On that cycle register win<=i_peek_data, vmask<=i_valid_data, hit<=0, idx<=lowest set index of vmask.
  - vmask all zero: back to PEEK; no pop is issued.
  - Otherwise go to SEND.
- SEND
  - o_valid=1, o_data=win[idx].
  - o_data is stable while o_valid && !i_ready; o_valid is never withdrawn before acceptance.
  - On i_ready: hit[idx]<=1, rem<=rem-1, idx<=next set index of vmask above idx.
  - If rem-1=0 or no further valid index exists, go to POP.
  - One word per cycle maximum (back-to-back acceptance allowed).
- POP
  - o_pop_en=1, o_data_hit=hit for exactly one cycle. Both are 0 in all other states.
  - Next state is DONE if rem=0, else PEEK.
  - Unsent valid entries (hit bit 0) stay in the FIFO. Their order relative to later words is the FIFO's responsibility.
- DONE: o_done=1 for one cycle, then go to IDLE.
- i_clear: takes priority over everything except reset.
  - Next state IDLE; outputs 0 next cycle.
  - No pop is issued, so captured but unacked words remain in the FIFO.
  - o_done does not pulse.
- Counter: rem is never decremented below 0. A count larger than the available data simply waits in PEEK for more.
- Latency, fifo non-empty to first o_valid: PEEK (1) + LATCH (>=1) = 2 cycles minimum.

Test Plan:
- Full window: FIFO preloaded with 9 words 0x01..0x09, i_count=4, i_ready=1.
  - Expect o_data 01,02,03,04 on 4 consecutive cycles.
  - Then o_pop_en=1 with o_data_hit=4'b1111, then o_done one cycle later, then IDLE.
- Multi-window: same preload, i_count=9.
  - Expect windows of 4, 4 and 1: hits 1111, 1111, 1000.
  - Stream 01..09 in order; exactly 3 pop pulses; o_done; FIFO empty.
- Partial/sparse mask: force i_valid_data=4'b1010 with data AA,BB,CC,DD, i_count=5.
  - Expect AA then CC, then pop with o_data_hit=4'b1010, then return to PEEK.
- Backpressure: i_ready low for 3 cycles during 0x02.
  - o_valid stays 1 and o_data holds 02; no duplicate and no skip; final hit 1111.
- Empty/zero cases: i_count=0 gives o_done on the cycle after start with no o_peek_en. Starting with an empty FIFO holds in PEEK with o_peek_en=0 until one write, then proceeds.
- Abort and reset:
  - i_clear asserted in SEND after 2 of 4 words: IDLE next cycle, o_pop_en never asserted, no o_done.
  - i_nrst dropped mid-SEND: all outputs 0 immediately.
